// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/control/decode side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pcsrc;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus8;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc, instr_pc_plus8,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  pcsrc, pc_target, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc, instr_pc_plus8,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output pcsrc, pc_target, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   tag_q     [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] count, outstanding, drop, drop_next;

  logic        req_valid, req_fire, rsp_in, redirect;
  logic        valid, push, pop;
  logic [31:0] target, head_pc;

  assign target   = {bus.pc_target[31:2], 2'b00};
  assign redirect = bus.pcsrc;
  assign rsp_in   = bus.imem_rsp_valid;
  assign valid    = count != '0;

  // Credit rule: every in-flight request has a reserved FIFO slot.
  assign req_valid = state == RUN
    && ({1'b0, outstanding} + {1'b0, count}) < DEPTH
    && outstanding < MAXO;
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign push      = state == RUN && rsp_in && !redirect;
  assign pop       = valid && bus.instr_ready && !redirect;
  assign drop_next = outstanding
    + (req_fire ? C1 : '0) - (rsp_in ? C1 : '0);
  assign head_pc   = valid ? fifo_pc[rd_ptr] : '0;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = valid;
  assign bus.instr          = valid ? fifo_data[rd_ptr] : '0;
  assign bus.instr_pc       = head_pc;
  assign bus.instr_pc_plus8 = head_pc + 32'd8;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rsp_data;
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
    end
    if (req_fire && !redirect)
      tag_q[tag_wr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          if (redirect) pc <= target;
        end
        RUN: begin
          if (redirect) begin
            pc          <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= drop_next;
            state       <= drop_next != '0 ? DRAIN : RUN;
          end else begin
            if (req_fire) begin
              pc     <= pc + 32'd4;
              tag_wr <= tag_wr + A1;
            end
            if (push) begin
              wr_ptr <= wr_ptr + A1;
              tag_rd <= tag_rd + A1;
            end
            if (pop) rd_ptr <= rd_ptr + A1;
            count <= count
              + (push ? C1 : '0) - (pop ? C1 : '0);
            outstanding <= outstanding
              + (req_fire ? C1 : '0) - (push ? C1 : '0);
          end
        end
        DRAIN: begin
          if (redirect) pc <= target;
          if (rsp_in && drop != '0) begin
            drop <= drop - C1;
            if (drop == C1) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && state == RUN)
        perf_fetched <= perf_fetched + 32'd1;
      if (state == RUN && redirect)
        perf_flushed <= perf_flushed + 32'(count) + 32'(rsp_in);
      else if (state == DRAIN && rsp_in && drop != '0)
        perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && rsp_in)
      assert ((state == RUN && outstanding != '0)
        || (state == DRAIN && drop != '0));
  end
`endif

endmodule
